// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and data (DM) requesters.
// Optional perf counters are enabled with MEM_PORT_ARB_PERF_EN.
//
// state | meaning
// IDLE  | no read in flight, free to grant
// RD_IF | fetch read in flight
// RD_DM | data load in flight
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_dm_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} arbState_e;

  arbState_e         state, stateNext;
  logic [CNT_W-1:0]  latCnt, latCntNext;
  logic [STV_W-1:0]  starveCnt, starveCntNext;
  logic [DATA_W-1:0] ifRdataQ, dmRdataQ;
  logic              lastRd, free, ifWins, ifGnt, dmGnt, ifRvalid, dmRvalid;

  // The last read cycle is also free so back-to-back reads overlap by one cycle.
  assign lastRd   = (state != IDLE) && (latCnt == LAST_CNT);
  assign free     = (state == IDLE) || lastRd;
  assign ifWins   = if_req && (!dm_req || (starveCnt == STARVE_TOP));
  assign ifGnt    = free && ifWins;
  assign dmGnt    = free && dm_req && !ifWins;
  assign ifRvalid = lastRd && (state == RD_IF);
  assign dmRvalid = lastRd && (state == RD_DM);

  always_comb begin
    stateNext     = state;
    latCntNext    = latCnt + CNT_W'(1);
    starveCntNext = starveCnt;
    if (ifGnt) begin
      stateNext  = RD_IF;
      latCntNext = '0;
    end else if (dmGnt && !dm_we) begin
      stateNext  = RD_DM;
      latCntNext = '0;
    end else if (dmGnt || free) begin
      stateNext  = IDLE;
      latCntNext = '0;
    end
    if (!if_req || ifGnt) begin
      starveCntNext = '0;
    end else if (dmGnt && (starveCnt != STARVE_TOP)) begin
      starveCntNext = starveCnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      latCnt    <= '0;
      starveCnt <= '0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
    end else begin
      state     <= stateNext;
      latCnt    <= latCntNext;
      starveCnt <= starveCntNext;
      if (ifRvalid) ifRdataQ <= mem_rdata;
      if (dmRvalid) dmRdataQ <= mem_rdata;
    end
  end

  // Reset is synchronous, so every output is gated to stay quiet while rst_n is low.
  always_comb begin
    if_gnt    = rst_n && ifGnt;
    dm_gnt    = rst_n && dmGnt;
    if_rvalid = rst_n && ifRvalid;
    dm_rvalid = rst_n && dmRvalid;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if_rdata = ifRvalid ? mem_rdata : ifRdataQ;
      dm_rdata = dmRvalid ? mem_rdata : dmRdataQ;
      if (dmGnt) begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else if (ifGnt) begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perfIfQ, perfDmQ, perfWaitQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perfIfQ   <= '0;
      perfDmQ   <= '0;
      perfWaitQ <= '0;
    end else begin
      if (ifGnt) perfIfQ <= perfIfQ + 32'd1;
      if (dmGnt) perfDmQ <= perfDmQ + 32'd1;
      if ((if_req && !ifGnt) || (dm_req && !dmGnt)) perfWaitQ <= perfWaitQ + 32'd1;
    end
  end

  assign perf_if_cnt   = rst_n ? perfIfQ : '0;
  assign perf_dm_cnt   = rst_n ? perfDmQ : '0;
  assign perf_wait_cnt = rst_n ? perfWaitQ : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4) with a latency-2 memory model.
// Perf counter checks compile in when MEM_PORT_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_cnt, perf_dm_cnt, perf_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  // Memory model: preloaded words plus a write overlay, read data appears two cycles after mem_req.
  bit [31:0]  wrData [0:511];
  bit [511:0] wrValid;
  bit [31:0]  rdPipe0, rdPipe1;

  function automatic bit [31:0] romWord(input logic [8:0] a);
    case (a)
      9'h004:  return 32'h00500093;
      9'h006:  return 32'h00000013;
      9'h010:  return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      wrData[mem_addr]  <= mem_wdata;
      wrValid[mem_addr] <= 1'b1;
    end
    rdPipe0 <= (mem_req && !mem_we) ? (wrValid[mem_addr] ? wrData[mem_addr] : romWord(mem_addr))
                                    : 32'hBAD0BAD0;
    rdPipe1 <= rdPipe0;
  end
  assign mem_rdata = rdPipe1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] expDm;
    logic [10:0] expIf;
    expDm = 11'b01111001111;
    expIf = 11'b10000010000;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_rdata", if_rdata, 0);
    tick();

    // Reset in the middle of a DM load
    rst_n = 1'b1; dm_req = 1'b1; dm_addr = 9'h010;
    @(negedge clk);
    chk("rstld_dm_gnt", dm_gnt, 1);
    tick();
    dm_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rstin_dm_gnt", dm_gnt, 0);
    chk("rstin_dm_rvalid", dm_rvalid, 0);
    chk("rstin_mem_req", mem_req, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstout_dm_rvalid", dm_rvalid, 0);
    chk("rstout_dm_rdata", dm_rdata, 0);
    chk("rstout_mem_req", mem_req, 0);
    tick();

    // Conflict: DM load wins, IF follows
    if_req = 1'b1; if_addr = 9'h004; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h010;
    @(negedge clk);
    chk("cf_dm_gnt", dm_gnt, 1);
    chk("cf_if_gnt", if_gnt, 0);
    chk("cf_mem_addr", mem_addr, 9'h010);
    chk("cf_mem_we", mem_we, 0);
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    chk("cf1_if_gnt", if_gnt, 0);
    chk("cf1_dm_rvalid", dm_rvalid, 0);
    tick();
    @(negedge clk);
    chk("cf2_if_gnt", if_gnt, 1);
    chk("cf2_mem_addr", mem_addr, 9'h004);
    chk("cf2_dm_rvalid", dm_rvalid, 1);
    chk("cf2_dm_rdata", dm_rdata, 32'h12345678);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("cf3_if_rvalid", if_rvalid, 0);
    chk("cf3_dm_rvalid", dm_rvalid, 0);
    chk("cf3_dm_rdata_hold", dm_rdata, 32'h12345678);
    tick();
    @(negedge clk);
    chk("cf4_if_rvalid", if_rvalid, 1);
    chk("cf4_if_rdata", if_rdata, 32'h00500093);
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_if", perf_if_cnt, 1);
    chk("perf_dm", perf_dm_cnt, 1);
    chk("perf_wait", perf_wait_cnt, 2);
`endif
    tick();

    // IF alone, back-to-back fetches
    if_req = 1'b1; if_addr = 9'h004;
    @(negedge clk);
    chk("if_gnt0", if_gnt, 1);
    chk("if_mem_req0", mem_req, 1);
    chk("if_mem_addr0", mem_addr, 9'h004);
    chk("if_mem_we0", mem_we, 0);
    tick();
    if_addr = 9'h006;
    @(negedge clk);
    chk("if_gnt1", if_gnt, 0);
    chk("if_mem_req1", mem_req, 0);
    chk("if_mem_addr1", mem_addr, 0);
    tick();
    @(negedge clk);
    chk("if_rvalid2", if_rvalid, 1);
    chk("if_rdata2", if_rdata, 32'h00500093);
    chk("if_gnt2", if_gnt, 1);
    chk("if_mem_addr2", mem_addr, 9'h006);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("if_rvalid3", if_rvalid, 0);
    chk("if_rdata3_hold", if_rdata, 32'h00500093);
    tick();
    @(negedge clk);
    chk("if_rvalid4", if_rvalid, 1);
    chk("if_rdata4", if_rdata, 32'h00000013);
    tick();

    // Store wins, IF granted next cycle
    if_req = 1'b1; if_addr = 9'h004;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h020; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_dm_gnt", dm_gnt, 1);
    chk("st_if_gnt", if_gnt, 0);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 9'h020);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk("st1_if_gnt", if_gnt, 1);
    chk("st1_dm_rvalid", dm_rvalid, 0);
    chk("st1_mem_we", mem_we, 0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("st2_dm_rvalid", dm_rvalid, 0);
    tick();
    @(negedge clk);
    chk("st3_if_rvalid", if_rvalid, 1);
    tick();
    dm_req = 1'b1; dm_addr = 9'h020;
    @(negedge clk);
    chk("ld_dm_gnt", dm_gnt, 1);
    tick();
    dm_req = 1'b0;
    tick();
    @(negedge clk);
    chk("ld_dm_rvalid", dm_rvalid, 1);
    chk("ld_dm_rdata", dm_rdata, 32'hDEADBEEF);
    tick();

    // Starvation: stores held with fetch pending
    if_req = 1'b1; if_addr = 9'h004;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h030; dm_wdata = 32'h0;
    for (int c = 0; c < 11; c++) begin
      if (c == 10) begin
        dm_req = 1'b0; dm_we = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("sv_dm_gnt_c%0d", c), dm_gnt, expDm[c]);
      chk($sformatf("sv_if_gnt_c%0d", c), if_gnt, expIf[c]);
      tick();
    end
    if_req = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
